entry_sequencer: RTL and testbench

Keypad entry controller for the calculator datapath. Accepts single-cycle key events and drives `stateEncoder`, `isNegative` and the three BCD digit lines. The operand registers sample these lines: operand 1 loads while `stateEncoder` = 01, operand 2 loads while it is 10. It also latches the selected operator, pulses `calc_start` to the ALU, and waits for `alu_done` before accepting a new calculation.

---
 rtl/calc_pkg.sv | 22 ++
 rtl/entry_sequencer_if.sv | 30 +++
 rtl/bcd_entry_shifter.sv | 68 ++++++
 rtl/entry_sequencer.sv | 95 +++++++++
 tb/tb_entry_sequencer.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared encodings for the calculator keypad and entry datapath.
package calc_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'b00,
    STATE_A       = 2'b01,
    STATE_B       = 2'b10,
    STATE_COMPUTE = 2'b11
  } state_t;

  localparam logic [3:0] KEY_NEG = 4'd10;
  localparam logic [3:0] KEY_OP  = 4'd11;
  localparam logic [3:0] KEY_EQ  = 4'd12;
  localparam logic [3:0] KEY_CE  = 4'd13;

  localparam int unsigned MAX_DIGITS = 3;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage

// File: rtl/entry_sequencer_if.sv
// Key/ALU handshake in, operand lines and control out.
interface entry_sequencer_if;
  import calc_pkg::*;

  logic       key_valid;
  logic [3:0] key_code;
  logic [1:0] op_sel;
  logic       alu_done;

  logic [1:0] stateEncoder;
  logic       isNegative;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic [1:0] digit_count;
  logic [1:0] op_latched;
  logic       calc_start;

  modport master (
    output key_valid, key_code, op_sel, alu_done,
    input  stateEncoder, isNegative, digit1, digit2, digit3,
           digit_count, op_latched, calc_start
  );

  modport slave (
    input  key_valid, key_code, op_sel, alu_done,
    output stateEncoder, isNegative, digit1, digit2, digit3,
           digit_count, op_latched, calc_start
  );
endinterface

// File: rtl/bcd_entry_shifter.sv
// Sign + 3-digit BCD entry register. A clear applies first, so a digit or
// sign set in the same cycle lands on a freshly zeroed operand.
module bcd_entry_shifter
  import calc_pkg::*;
(
  input  logic       Clock,
  input  logic       reset,
  input  logic       clr,
  input  logic       shift_en,
  input  logic [3:0] digit,
  input  logic       neg_toggle,
  input  logic       set_neg,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [1:0] digit_count,
  output logic       is_neg
);

  logic [3:0] base_d1, base_d2, base_d3;
  logic [1:0] base_cnt;
  logic       base_neg;
  logic [3:0] nxt_d1, nxt_d2, nxt_d3;
  logic [1:0] nxt_cnt;
  logic       nxt_neg;
  logic       accept;

  always_comb begin
    base_d1  = clr ? 4'd0 : digit1;
    base_d2  = clr ? 4'd0 : digit2;
    base_d3  = clr ? 4'd0 : digit3;
    base_cnt = clr ? 2'd0 : digit_count;
    base_neg = clr ? 1'b0 : is_neg;

    // Full operands drop digits; a zero before any significant digit is a no-op.
    accept = shift_en && (base_cnt < 2'(MAX_DIGITS)) &&
             !(base_cnt == 2'd0 && digit == 4'd0);

    nxt_d1  = base_d1;
    nxt_d2  = base_d2;
    nxt_d3  = base_d3;
    nxt_cnt = base_cnt;
    if (accept) begin
      nxt_d3  = base_d2;
      nxt_d2  = base_d1;
      nxt_d1  = digit;
      nxt_cnt = base_cnt + 2'd1;
    end
    nxt_neg = set_neg ? 1'b1 : (base_neg ^ neg_toggle);
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      digit1      <= '0;
      digit2      <= '0;
      digit3      <= '0;
      digit_count <= '0;
      is_neg      <= 1'b0;
    end else begin
      digit1      <= nxt_d1;
      digit2      <= nxt_d2;
      digit3      <= nxt_d3;
      digit_count <= nxt_cnt;
      is_neg      <= nxt_neg;
    end
  end

endmodule

// File: rtl/entry_sequencer.sv
// Keypad entry FSM: steers operand entry A/B, latches the operator and
// kicks the ALU, then waits for alu_done.
module entry_sequencer
  import calc_pkg::*;
(
  input  logic              Clock,
  input  logic              reset,
  entry_sequencer_if.slave  bus
);

  state_t     state;
  logic [1:0] op_reg;
  logic       start_reg;

  logic clr, shift_en, neg_toggle, set_neg;
  logic key_digit;

  assign key_digit = is_digit(bus.key_code);

  // Key decode into shifter controls; COMPUTE ignores every key.
  always_comb begin
    clr        = 1'b0;
    shift_en   = 1'b0;
    neg_toggle = 1'b0;
    set_neg    = 1'b0;
    if (bus.key_valid) begin
      unique case (state)
        STATE_IDLE: begin
          if (key_digit) begin
            clr      = 1'b1;
            shift_en = 1'b1;
          end else if (bus.key_code == KEY_NEG) begin
            clr     = 1'b1;
            set_neg = 1'b1;
          end
        end
        STATE_A, STATE_B: begin
          if (key_digit)                   shift_en   = 1'b1;
          else if (bus.key_code == KEY_NEG) neg_toggle = 1'b1;
          else if (bus.key_code == KEY_CE)  clr        = 1'b1;
          else if (bus.key_code == KEY_OP && state == STATE_A) clr = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      state     <= STATE_IDLE;
      op_reg    <= '0;
      start_reg <= 1'b0;
    end else begin
      start_reg <= 1'b0;
      unique case (state)
        STATE_IDLE:
          if (bus.key_valid && (key_digit || bus.key_code == KEY_NEG))
            state <= STATE_A;
        STATE_A:
          if (bus.key_valid && bus.key_code == KEY_OP) begin
            op_reg <= bus.op_sel;
            state  <= STATE_B;
          end
        STATE_B:
          if (bus.key_valid && bus.key_code == KEY_EQ) begin
            state     <= STATE_COMPUTE;
            start_reg <= 1'b1;
          end
        STATE_COMPUTE:
          if (bus.alu_done) state <= STATE_IDLE;
        default: state <= STATE_IDLE;
      endcase
    end
  end

  assign bus.stateEncoder = state;
  assign bus.op_latched   = op_reg;
  assign bus.calc_start   = start_reg;

  bcd_entry_shifter u_shifter (
    .Clock       (Clock),
    .reset       (reset),
    .clr         (clr),
    .shift_en    (shift_en),
    .digit       (bus.key_code),
    .neg_toggle  (neg_toggle),
    .set_neg     (set_neg),
    .digit1      (bus.digit1),
    .digit2      (bus.digit2),
    .digit3      (bus.digit3),
    .digit_count (bus.digit_count),
    .is_neg      (bus.isNegative)
  );

endmodule

// File: tb/tb_entry_sequencer.sv
// Scoreboard bench: an integer-valued operand model predicts every cycle's
// outputs; a monitor compares them after each rising edge.
module tb_entry_sequencer;

  typedef struct packed {
    logic [1:0] st;
    logic       neg;
    logic [3:0] d3, d2, d1;
    logic [1:0] cnt;
    logic [1:0] op;
    logic       cs;
  } snap_t;

  logic Clock = 1'b0;
  logic reset = 1'b1;
  entry_sequencer_if bus();

  entry_sequencer dut (.Clock(Clock), .reset(reset), .bus(bus));

  always #5 Clock = ~Clock;

  snap_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Model: operand held as a decimal value plus count; states as plain ints.
  int m_state = 0;   // 0 idle, 1 entering A, 2 entering B, 3 computing
  int m_val = 0, m_cnt = 0, m_neg = 0, m_op = 0, m_cs = 0;

  task automatic model_clear();
    m_val = 0; m_cnt = 0; m_neg = 0;
  endtask

  task automatic model_digit(input int d);
    if (m_cnt < 3 && !(m_cnt == 0 && d == 0)) begin
      m_val = m_val * 10 + d;
      m_cnt++;
    end
  endtask

  task automatic model(input bit r, input bit kv, input int kc, input int op, input bit dn);
    m_cs = 0;
    if (r) begin
      m_state = 0; model_clear(); m_op = 0;
    end else if (m_state == 3) begin
      if (dn) m_state = 0;
    end else if (kv) begin
      if (kc <= 9) begin
        if (m_state == 0) begin model_clear(); m_state = 1; end
        model_digit(kc);
      end else if (kc == 10) begin
        if (m_state == 0) begin model_clear(); m_neg = 1; m_state = 1; end
        else m_neg = !m_neg;
      end else if (kc == 11) begin
        if (m_state == 1) begin m_op = op; m_state = 2; model_clear(); end
      end else if (kc == 12) begin
        if (m_state == 2) begin m_state = 3; m_cs = 1; end
      end else if (kc == 13) begin
        if (m_state != 0) model_clear();
      end
    end
  endtask

  function automatic snap_t model_snap();
    snap_t s;
    s.st  = 2'(m_state);
    s.neg = m_neg[0];
    s.d1  = 4'(m_val % 10);
    s.d2  = 4'((m_val / 10) % 10);
    s.d3  = 4'(m_val / 100);
    s.cnt = 2'(m_cnt);
    s.op  = 2'(m_op);
    s.cs  = m_cs[0];
    return s;
  endfunction

  task automatic step(input bit r, input bit kv, input int kc, input int op, input bit dn);
    reset         = r;
    bus.key_valid = kv;
    bus.key_code  = 4'(kc);
    bus.op_sel    = 2'(op);
    bus.alu_done  = dn;
    model(r, kv, kc, op, dn);
    exp_q.push_back(model_snap());
    @(negedge Clock);
  endtask

  task automatic key(input int kc, input int op = 0);
    step(0, 1, kc, op, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // Monitor: every output cycle that has a prediction queued is compared.
  initial begin
    snap_t e, a;
    forever begin
      @(posedge Clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = '{bus.stateEncoder, bus.isNegative, bus.digit3, bus.digit2, bus.digit1,
              bus.digit_count, bus.op_latched, bus.calc_start};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got st=%b neg=%b d=%h%h%h cnt=%0d op=%0d cs=%b required st=%b neg=%b d=%h%h%h cnt=%0d op=%0d cs=%b",
                   $time, a.st, a.neg, a.d3, a.d2, a.d1, a.cnt, a.op, a.cs,
                   e.st, e.neg, e.d3, e.d2, e.d1, e.cnt, e.op, e.cs);
        end
      end
    end
  end

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = '0;
    bus.op_sel    = '0;
    bus.alu_done  = 1'b0;
    @(negedge Clock);

    step(1, 0, 0, 0, 0); step(1, 0, 0, 0, 0);
    // 1,2,3 fill the operand, 4 dropped
    key(1); key(2); key(3); key(4); idle(1);
    step(1, 0, 0, 0, 0);
    // leading zeros suppressed, then negate
    key(0); key(0); key(7); key(10); idle(1);
    // operator/equals into compute
    key(5); key(11, 2); key(9); key(12); idle(3);
    // done together with a key: key dropped
    step(0, 1, 3, 0, 1); key(4); idle(1);
    // clear-entry in B, equals in A ignored
    step(1, 0, 0, 0, 0);
    key(1); key(11, 1); key(4); key(5); key(13); idle(1);
    step(1, 0, 0, 0, 0);
    key(6); key(12); key(11, 3); key(12); idle(1);
    // reset mid-compute and mid-entry
    step(1, 0, 0, 0, 0); key(8); idle(1);
    key(2); key(1); step(1, 1, 3, 0, 0); idle(1);
    // alu_done outside compute is ignored
    key(10); step(0, 0, 0, 0, 1); key(3); idle(1);

    for (int i = 0; i < 3000; i++) begin
      bit r, kv, dn;
      int kc;
      r  = ($urandom_range(99) == 0);
      kv = $urandom_range(1) == 1;
      kc = ($urandom_range(9) < 6) ? int'($urandom_range(9)) : int'($urandom_range(15, 10));
      dn = ($urandom_range(7) == 0);
      step(r, kv, kc, int'($urandom_range(3)), dn);
    end

    idle(2);
    bus.key_valid = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
